// File: rtl/retire_trace_buffer.sv
// Purpose : capture retired PCs into a FWFT trace FIFO with sequence tags, count retirements, detect jump-to-self halt.
// Latency : a push into an empty FIFO shows on o_trace_* one cycle later (never bypassed); pop is same-cycle.
// Backpressure: i_trace_rdy low holds the head; a retirement into a full FIFO without a pop is dropped and o_overflow is set.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_pc_debug / i_insn_vld : retirement input (sampled only when i_insn_vld=1)
//   i_clear                 : synchronous clear of all state
//   o_trace_pc/o_trace_seq/o_trace_vld, i_trace_rdy : trace drain port
//   o_full, o_empty, o_overflow, o_retire_cnt, o_halt : status
module retire_trace_buffer #(
    parameter int DEPTH       = 16,
    parameter int HALT_REPEAT = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc_debug,
    input  logic        i_insn_vld,
    input  logic        i_clear,
    output logic [31:0] o_trace_pc,
    output logic [15:0] o_trace_seq,
    output logic        o_trace_vld,
    input  logic        i_trace_rdy,
    output logic        o_full,
    output logic        o_empty,
    output logic        o_overflow,
    output logic [31:0] o_retire_cnt,
    output logic        o_halt
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam logic [RW-1:0] REP_ONE = RW'(1);
    localparam logic [RW-1:0] REP_MAX = RW'(HALT_REPEAT);

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] seq;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [31:0]     last_pc;
    logic            last_pc_vld;
    logic [RW-1:0]   rep;
    logic [RW-1:0]   rep_nxt;
    logic            overflow;
    logic            halt;
    logic [31:0]     retire_cnt;

    logic            full;
    logic            empty;
    logic            accept;
    logic            pop;
    logic            push_ok;
    logic            same_pc;
    entry_t          head;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Clear wins over everything, halt freezes the retirement side.
    assign accept  = i_insn_vld && !halt && !i_clear;
    assign pop     = !empty && i_trace_rdy && !i_clear;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = accept && (!full || pop);

    always_comb begin
        same_pc = last_pc_vld && (i_pc_debug == last_pc);
        rep_nxt = REP_ONE;
        if (same_pc) begin
            rep_nxt = (rep == REP_MAX) ? rep : rep + REP_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_pc     <= '0;
            last_pc_vld <= 1'b0;
            rep         <= '0;
            overflow    <= 1'b0;
            halt        <= 1'b0;
            retire_cnt  <= '0;
        end else if (i_clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_pc     <= '0;
            last_pc_vld <= 1'b0;
            rep         <= '0;
            overflow    <= 1'b0;
            halt        <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            if (accept) begin
                retire_cnt  <= retire_cnt + 32'd1;
                last_pc     <= i_pc_debug;
                last_pc_vld <= 1'b1;
                rep         <= rep_nxt;
                if (rep_nxt == REP_MAX) begin
                    halt <= 1'b1;
                end
                if (full && !pop) begin
                    overflow <= 1'b1;
                end
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset; the empty decode masks stale contents.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= '{pc: i_pc_debug, seq: retire_cnt[15:0]};
        end
    end

    assign head         = mem[rd_ptr[AW-1:0]];
    assign o_trace_pc   = empty ? 32'd0 : head.pc;
    assign o_trace_seq  = empty ? 16'd0 : head.seq;
    assign o_trace_vld  = !empty;
    assign o_full       = full;
    assign o_empty      = empty;
    assign o_overflow   = overflow;
    assign o_retire_cnt = retire_cnt;
    assign o_halt       = halt;

endmodule

// File: tb/tb_retire_trace_buffer.sv
module tb_retire_trace_buffer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_pc_debug;
    logic        i_insn_vld;
    logic        i_clear;
    logic [31:0] o_trace_pc;
    logic [15:0] o_trace_seq;
    logic        o_trace_vld;
    logic        i_trace_rdy;
    logic        o_full;
    logic        o_empty;
    logic        o_overflow;
    logic [31:0] o_retire_cnt;
    logic        o_halt;

    int n_tests = 0;
    int n_fail  = 0;

    retire_trace_buffer #(.DEPTH(16), .HALT_REPEAT(2)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_pc_debug   (i_pc_debug),
        .i_insn_vld   (i_insn_vld),
        .i_clear      (i_clear),
        .o_trace_pc   (o_trace_pc),
        .o_trace_seq  (o_trace_seq),
        .o_trace_vld  (o_trace_vld),
        .i_trace_rdy  (i_trace_rdy),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_overflow   (o_overflow),
        .o_retire_cnt (o_retire_cnt),
        .o_halt       (o_halt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns so outputs are sampled off the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc);
        i_pc_debug = pc;
        i_insn_vld = 1'b1;
        tick();
        i_insn_vld = 1'b0;
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [15:0] seq);
        chk({tag, "_vld"}, {31'd0, o_trace_vld}, 32'd1);
        chk({tag, "_pc"},  o_trace_pc, pc);
        chk({tag, "_seq"}, {16'd0, o_trace_seq}, {16'd0, seq});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_empty"}, {31'd0, o_empty},     32'd1);
        chk({tag, "_vld"},   {31'd0, o_trace_vld}, 32'd0);
        chk({tag, "_full"},  {31'd0, o_full},      32'd0);
        chk({tag, "_ovf"},   {31'd0, o_overflow},  32'd0);
        chk({tag, "_halt"},  {31'd0, o_halt},      32'd0);
        chk({tag, "_cnt"},   o_retire_cnt,         32'd0);
        chk({tag, "_pc"},    o_trace_pc,           32'd0);
        chk({tag, "_seq"},   {16'd0, o_trace_seq}, 32'd0);
    endtask

    initial begin
        i_reset     = 1'b0;
        i_pc_debug  = 32'd0;
        i_insn_vld  = 1'b0;
        i_clear     = 1'b0;
        i_trace_rdy = 1'b0;

        // Reset / idle
        repeat (3) tick();
        chk_idle("rst_hold");
        i_reset = 1'b1;
        tick();
        chk_idle("rst_rel");

        // In-order capture
        retire(32'h0);
        chk_head("fwft_first", 32'h0, 16'd0);
        chk("fwft_cnt", o_retire_cnt, 32'd1);
        retire(32'h4);
        tick();
        retire(32'h8);
        chk("order_cnt", o_retire_cnt, 32'd3);
        chk_head("order_head", 32'h0, 16'd0);
        i_trace_rdy = 1'b1;
        tick();
        chk_head("order_pop1", 32'h4, 16'd1);
        tick();
        chk_head("order_pop2", 32'h8, 16'd2);
        tick();
        i_trace_rdy = 1'b0;
        chk("order_empty", {31'd0, o_empty}, 32'd1);
        chk("order_nohalt", {31'd0, o_halt}, 32'd0);
        // Ready while empty is harmless
        i_trace_rdy = 1'b1;
        tick();
        i_trace_rdy = 1'b0;
        chk("rdy_empty", {31'd0, o_empty}, 32'd1);

        // Full / overflow
        do_clear();
        chk_idle("clr1");
        for (int i = 0; i < 16; i++) retire(32'h100 + 32'(4 * i));
        chk("full16", {31'd0, o_full}, 32'd1);
        chk("full16_ovf", {31'd0, o_overflow}, 32'd0);
        retire(32'h140);
        chk("ovf_set", {31'd0, o_overflow}, 32'd1);
        chk("ovf_cnt", o_retire_cnt, 32'd17);
        chk("ovf_full", {31'd0, o_full}, 32'd1);
        chk_head("ovf_head", 32'h100, 16'd0);
        i_trace_rdy = 1'b1;
        retire(32'h144);
        i_trace_rdy = 1'b0;
        chk_head("pushpop_head", 32'h104, 16'd1);
        chk("pushpop_full", {31'd0, o_full}, 32'd1);
        chk("pushpop_cnt", o_retire_cnt, 32'd18);
        i_trace_rdy = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk_head("drain", 32'h100 + 32'(4 * i), 16'(i));
            tick();
        end
        chk_head("tail", 32'h144, 16'd17);
        tick();
        i_trace_rdy = 1'b0;
        chk("drain_empty", {31'd0, o_empty}, 32'd1);
        chk("drain_ovf_sticky", {31'd0, o_overflow}, 32'd1);

        // Halt detection
        do_clear();
        retire(32'h10);
        retire(32'h14);
        chk("halt_pre", {31'd0, o_halt}, 32'd0);
        tick();
        chk("halt_gap", {31'd0, o_halt}, 32'd0);
        retire(32'h14);
        chk("halt_set", {31'd0, o_halt}, 32'd1);
        chk("halt_cnt", o_retire_cnt, 32'd3);
        retire(32'h14);
        retire(32'h18);
        chk("halt_frozen_cnt", o_retire_cnt, 32'd3);
        i_trace_rdy = 1'b1;
        chk_head("halt_e0", 32'h10, 16'd0);
        tick();
        chk_head("halt_e1", 32'h14, 16'd1);
        tick();
        chk_head("halt_e2", 32'h14, 16'd2);
        tick();
        i_trace_rdy = 1'b0;
        chk("halt_fifo3", {31'd0, o_empty}, 32'd1);
        chk("halt_sticky", {31'd0, o_halt}, 32'd1);

        // Clear collision
        do_clear();
        for (int i = 0; i < 17; i++) retire(32'h200 + 32'(4 * i));
        i_trace_rdy = 1'b1;
        repeat (12) tick();
        i_trace_rdy = 1'b0;
        chk("col_ovf", {31'd0, o_overflow}, 32'd1);
        chk_head("col_head", 32'h230, 16'd12);
        i_clear     = 1'b1;
        i_insn_vld  = 1'b1;
        i_pc_debug  = 32'h300;
        i_trace_rdy = 1'b1;
        tick();
        i_clear     = 1'b0;
        i_insn_vld  = 1'b0;
        i_trace_rdy = 1'b0;
        chk_idle("col_clr");

        // Async reset mid-stream
        for (int i = 0; i < 6; i++) retire(32'h20 + 32'(4 * i));
        retire(32'h38);
        retire(32'h38);
        chk("ar_halt", {31'd0, o_halt}, 32'd1);
        chk("ar_cnt", o_retire_cnt, 32'd8);
        chk("ar_vld", {31'd0, o_trace_vld}, 32'd1);
        #2;
        i_reset = 1'b0;
        #1;
        chk_idle("ar_async");
        #1;
        i_reset = 1'b1;
        tick();
        chk_idle("ar_rel");
        retire(32'h14);
        chk("ar_one_nohalt", {31'd0, o_halt}, 32'd0);
        chk("ar_one_cnt", o_retire_cnt, 32'd1);
        retire(32'h14);
        chk("ar_two_halt", {31'd0, o_halt}, 32'd1);
        chk("ar_two_cnt", o_retire_cnt, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
